// File: rtl/move_sched.sv
// Move scheduler: collects button/gravity requests, issues them one at a time
// to the piece tracker and commits the tracker's frame when the move is legal.
module move_sched #(
  parameter int REPEAT_DLY = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 play,
  input  logic                 btn_right,
  input  logic                 btn_left,
  input  logic                 btn_ror,
  input  logic                 btn_rol,
  input  logic                 drop_tick,
  input  logic                 load_frame,
  input  logic [4:0][4:0][2:0] frame_init,
  input  logic [4:0][4:0][2:0] trk_frame,
  input  logic                 trk_check,
  input  logic                 trk_complete,
  output logic [2:0]           move,
  output logic                 move_valid,
  output logic [4:0][4:0][2:0] frame_cur,
  output logic                 landed,
  output logic [7:0]           reject_cnt
);

  localparam logic [2:0] MV_DOWN  = 3'd4;
  localparam logic [7:0] REP_LAST = 8'(REPEAT_DLY);

  typedef enum logic [1:0] {IDLE, ISSUE, LOCKED} state_t;

  state_t     state_reg;
  logic [4:0] pending_reg;
  logic [3:0] btn_prev_reg;
  logic [3:0] btn_lvl;
  logic [3:0] btn_req;
  logic [4:0] req;
  logic [4:0] grant_oh;
  logic [2:0] grant_code;

  // Button bit index equals its move code, so req lines up with pending bits.
  assign btn_lvl = {btn_rol, btn_ror, btn_left, btn_right};
  assign req     = {drop_tick, btn_req};

  always_ff @(posedge clk) begin
    if (!rst) btn_prev_reg <= '0;
    else      btn_prev_reg <= btn_lvl;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rep
      logic [7:0] cnt_reg;
      logic       edge_hit;
      logic       rep_hit;

      assign edge_hit = btn_lvl[gi] && !btn_prev_reg[gi];
      assign rep_hit  = btn_lvl[gi] && btn_prev_reg[gi] && (cnt_reg == REP_LAST);
      assign btn_req[gi] = edge_hit || rep_hit;

      // cnt_reg counts cycles since the last edge/repeat; zero means not armed.
      always_ff @(posedge clk) begin
        if (!rst || !play || !btn_lvl[gi]) cnt_reg <= '0;
        else if (edge_hit || rep_hit)      cnt_reg <= 8'd1;
        else if (cnt_reg != '0)            cnt_reg <= cnt_reg + 8'd1;
      end
    end
  endgenerate

  always_comb begin
    grant_oh   = '0;
    grant_code = 3'd0;
    if (pending_reg[4]) begin
      grant_oh   = 5'b10000;
      grant_code = 3'd4;
    end else if (pending_reg[2]) begin
      grant_oh   = 5'b00100;
      grant_code = 3'd2;
    end else if (pending_reg[3]) begin
      grant_oh   = 5'b01000;
      grant_code = 3'd3;
    end else if (pending_reg[1]) begin
      grant_oh   = 5'b00010;
      grant_code = 3'd1;
    end else if (pending_reg[0]) begin
      grant_oh   = 5'b00001;
      grant_code = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      move        <= 3'd0;
      move_valid  <= 1'b0;
      frame_cur   <= '0;
      landed      <= 1'b0;
      reject_cnt  <= '0;
    end else begin
      landed     <= 1'b0;
      move_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!play) begin
            pending_reg <= '0;
            if (load_frame) frame_cur <= frame_init;
          end else if (load_frame) begin
            frame_cur   <= frame_init;
            pending_reg <= pending_reg | req;
          end else if (|pending_reg) begin
            // A fresh request for the granted move survives the clear.
            pending_reg <= (pending_reg & ~grant_oh) | req;
            move        <= grant_code;
            move_valid  <= 1'b1;
            state_reg   <= ISSUE;
          end else begin
            pending_reg <= pending_reg | req;
          end
        end
        ISSUE: begin
          if (!play) begin
            pending_reg <= '0;
            state_reg   <= IDLE;
          end else begin
            if (trk_check)                frame_cur  <= trk_frame;
            else if (reject_cnt != 8'hFF) reject_cnt <= reject_cnt + 8'd1;
            if (move == MV_DOWN && trk_complete) begin
              landed      <= 1'b1;
              pending_reg <= '0;
              state_reg   <= LOCKED;
            end else begin
              pending_reg <= pending_reg | req;
              state_reg   <= IDLE;
            end
          end
        end
        LOCKED: begin
          pending_reg <= '0;
          if (load_frame) begin
            frame_cur <= frame_init;
            state_reg <= IDLE;
          end else if (!play) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_sched.sv
// Bench for move_sched: a directed vector table, multi-cycle corner sequences,
// then randomized traffic compared against a rule-level reference model.
`timescale 1ns/1ps
module tb_move_sched;

  localparam int RDLY = 8;
  typedef logic [4:0][4:0][2:0] frame_t;

  logic       clk = 1'b0;
  logic       rst, play, btn_right, btn_left, btn_ror, btn_rol;
  logic       drop_tick, load_frame, trk_check, trk_complete;
  frame_t     frame_init, trk_frame, frame_cur;
  logic [2:0] move;
  logic       move_valid, landed;
  logic [7:0] reject_cnt;

  move_sched #(.REPEAT_DLY(RDLY)) dut (
    .clk(clk), .rst(rst), .play(play),
    .btn_right(btn_right), .btn_left(btn_left), .btn_ror(btn_ror), .btn_rol(btn_rol),
    .drop_tick(drop_tick), .load_frame(load_frame),
    .frame_init(frame_init), .trk_frame(trk_frame),
    .trk_check(trk_check), .trk_complete(trk_complete),
    .move(move), .move_valid(move_valid), .frame_cur(frame_cur),
    .landed(landed), .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  frame_t fr_zero, fr_init, fr_shift;

  function automatic frame_t frame_of(input int sel);
    if (sel == 1) return fr_init;
    if (sel == 2) return fr_shift;
    return fr_zero;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        f[r][c] = 3'($urandom_range(0, 7));
    return f;
  endfunction

  // Directed vector: inputs for one cycle and the outputs expected after it.
  typedef struct {
    bit       r;
    bit [3:0] b;      // {rol, ror, left, right}
    bit       d, l, c, cp;
    bit       e_valid;
    bit [2:0] e_move;
    bit       e_landed;
    bit [7:0] e_rej;
    int       e_fr;   // 0 zero, 1 init, 2 shifted
  } vec_t;

  function automatic vec_t mk(input bit r, input bit [3:0] b, input bit d, input bit l,
                              input bit c, input bit cp, input bit v, input bit [2:0] mv,
                              input bit ld, input bit [7:0] rj, input int fr);
    vec_t t;
    t.r = r; t.b = b; t.d = d; t.l = l; t.c = c; t.cp = cp;
    t.e_valid = v; t.e_move = mv; t.e_landed = ld; t.e_rej = rj; t.e_fr = fr;
    return t;
  endfunction

  // Reference model: rule-level view of the scheduler.
  int       m_phase;    // 0 idle, 1 issuing, 2 locked
  bit [4:0] m_pend;
  int       m_held[4];  // cycles since press edge, -1 when not tracking
  bit [3:0] m_prev;
  bit [2:0] m_move;
  bit       m_valid, m_landed;
  frame_t   m_frame;
  int       m_rej;

  task automatic model_step();
    bit [3:0] b;
    bit [4:0] r;
    int       prio[5];
    int       g;
    prio = '{4, 2, 3, 1, 0};
    b = {btn_rol, btn_ror, btn_left, btn_right};
    r = '0;
    if (!rst) begin
      m_phase = 0; m_pend = '0; m_prev = '0; m_move = 3'd0;
      m_valid = 0; m_landed = 0; m_frame = '0; m_rej = 0;
      for (int i = 0; i < 4; i++) m_held[i] = -1;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      if (!b[i]) m_held[i] = -1;
      else if (!m_prev[i]) begin
        m_held[i] = 0;
        r[i] = 1'b1;
      end else if (m_held[i] >= 0) begin
        m_held[i]++;
        if (m_held[i] % RDLY == 0) r[i] = 1'b1;
      end
      if (!play) m_held[i] = -1;
    end
    m_prev = b;
    r[4] = drop_tick;
    m_valid = 0;
    m_landed = 0;
    case (m_phase)
      0: begin
        if (!play) begin
          m_pend = '0;
          if (load_frame) m_frame = frame_init;
        end else if (load_frame) begin
          m_frame = frame_init;
          m_pend |= r;
        end else if (m_pend != 0) begin
          g = -1;
          for (int k = 0; k < 5; k++)
            if (g < 0 && m_pend[prio[k]]) g = prio[k];
          m_pend[g] = 1'b0;
          m_pend |= r;
          m_move = 3'(g);
          m_valid = 1;
          m_phase = 1;
        end else begin
          m_pend |= r;
        end
      end
      1: begin
        if (!play) begin
          m_pend = '0;
          m_phase = 0;
        end else begin
          if (trk_check) m_frame = trk_frame;
          else if (m_rej < 255) m_rej++;
          if (m_move == 3'd4 && trk_complete) begin
            m_landed = 1;
            m_pend = '0;
            m_phase = 2;
          end else begin
            m_pend |= r;
            m_phase = 0;
          end
        end
      end
      default: begin
        m_pend = '0;
        if (load_frame) begin
          m_frame = frame_init;
          m_phase = 0;
        end else if (!play) begin
          m_phase = 0;
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    play = 1; btn_right = 0; btn_left = 0; btn_ror = 0; btn_rol = 0;
    drop_tick = 0; load_frame = 0; trk_check = 1; trk_complete = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    tick();
    tick();
    rst = 1;
  endtask

  vec_t tv[27];

  initial begin
    int  n;
    bit [3:0] rb;
    fr_zero = '0;
    fr_init = '0;
    fr_init[1][1] = 3'd1; fr_init[1][2] = 3'd1; fr_init[2][1] = 3'd1; fr_init[2][2] = 3'd1;
    fr_shift = '0;
    fr_shift[1][2] = 3'd1; fr_shift[1][3] = 3'd1; fr_shift[2][2] = 3'd1; fr_shift[2][3] = 3'd1;

    tv[0]  = mk(0, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tv[1]  = mk(1, 4'b0000, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    tv[2]  = mk(1, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    tv[3]  = mk(1, 4'b0001, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    tv[4]  = mk(1, 4'b0000, 0, 0, 1, 0, 1, 0, 0, 0, 1);
    tv[5]  = mk(1, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0, 2);
    tv[6]  = mk(1, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0, 2);
    tv[7]  = mk(1, 4'b0100, 1, 0, 1, 0, 0, 0, 0, 0, 2);
    tv[8]  = mk(1, 4'b0000, 0, 0, 0, 0, 1, 4, 0, 0, 2);
    tv[9]  = mk(1, 4'b0000, 0, 0, 0, 0, 0, 4, 0, 1, 2);
    tv[10] = mk(1, 4'b0000, 0, 0, 0, 0, 1, 2, 0, 1, 2);
    tv[11] = mk(1, 4'b0000, 0, 0, 0, 0, 0, 2, 0, 2, 2);
    tv[12] = mk(1, 4'b0000, 0, 0, 1, 0, 0, 2, 0, 2, 2);
    tv[13] = mk(1, 4'b0000, 1, 0, 1, 0, 0, 2, 0, 2, 2);
    tv[14] = mk(1, 4'b0000, 0, 0, 1, 1, 1, 4, 0, 2, 2);
    tv[15] = mk(1, 4'b0000, 0, 0, 1, 1, 0, 4, 1, 2, 2);
    tv[16] = mk(1, 4'b0001, 0, 0, 1, 0, 0, 4, 0, 2, 2);
    tv[17] = mk(1, 4'b0000, 0, 0, 1, 0, 0, 4, 0, 2, 2);
    tv[18] = mk(1, 4'b0000, 0, 1, 1, 0, 0, 4, 0, 2, 1);
    tv[19] = mk(1, 4'b0000, 0, 0, 1, 0, 0, 4, 0, 2, 1);
    tv[20] = mk(1, 4'b0001, 0, 0, 1, 0, 0, 4, 0, 2, 1);
    tv[21] = mk(1, 4'b0000, 0, 0, 1, 0, 1, 0, 0, 2, 1);
    tv[22] = mk(1, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 2, 2);
    tv[23] = mk(1, 4'b0010, 0, 0, 1, 0, 0, 0, 0, 2, 2);
    tv[24] = mk(1, 4'b0000, 0, 0, 1, 0, 1, 1, 0, 2, 2);
    tv[25] = mk(0, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tv[26] = mk(1, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    idle_inputs();
    rst = 0;
    frame_init = fr_init;
    trk_frame  = fr_shift;

    for (int i = 0; i < 27; i++) begin
      rst = tv[i].r;
      {btn_rol, btn_ror, btn_left, btn_right} = tv[i].b;
      drop_tick = tv[i].d; load_frame = tv[i].l;
      trk_check = tv[i].c; trk_complete = tv[i].cp;
      tick();
      chk($sformatf("vec%0d_valid", i),  80'(move_valid), 80'(tv[i].e_valid));
      chk($sformatf("vec%0d_move", i),   80'(move),       80'(tv[i].e_move));
      chk($sformatf("vec%0d_landed", i), 80'(landed),     80'(tv[i].e_landed));
      chk($sformatf("vec%0d_rej", i),    80'(reject_cnt), 80'(tv[i].e_rej));
      chk($sformatf("vec%0d_frame", i),  80'(frame_cur),  80'(frame_of(tv[i].e_fr)));
    end

    // Held LEFT: one grant for the edge plus one per completed repeat period.
    do_reset();
    load_frame = 1;
    tick();
    load_frame = 0;
    btn_left = 1;
    n = 0;
    for (int c = 0; c < 36; c++) begin
      if (c == 30) btn_left = 0;
      tick();
      if (move_valid && move == 3'd1) n++;
    end
    chk("hold_left_grants", 80'(n), 80'd4);

    // Rejected ROL presses: frame untouched, counter saturates at 255.
    do_reset();
    load_frame = 1;
    tick();
    load_frame = 0;
    trk_check = 0;
    for (int p = 1; p <= 300; p++) begin
      btn_rol = 1;
      tick();
      btn_rol = 0;
      tick(); tick(); tick();
      if (p == 254) chk("rej_at_254", 80'(reject_cnt), 80'd254);
    end
    chk("rej_saturated", 80'(reject_cnt), 80'd255);
    chk("rej_frame_kept", 80'(frame_cur), 80'(fr_init));
    chk("rej_last_move", 80'(move), 80'd3);

    // Randomized traffic against the reference model.
    idle_inputs();
    rb = '0;
    for (int c = 0; c < 3000; c++) begin
      rst = (c == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
      play = ($urandom_range(0, 99) >= 3);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 9) == 0) rb[i] = ~rb[i];
      {btn_rol, btn_ror, btn_left, btn_right} = rb;
      drop_tick    = ($urandom_range(0, 9) == 0);
      load_frame   = ($urandom_range(0, 99) < 4);
      trk_check    = ($urandom_range(0, 9) < 7);
      trk_complete = ($urandom_range(0, 9) < 3);
      trk_frame    = rand_frame();
      if ($urandom_range(0, 19) == 0) frame_init = rand_frame();
      tick();
      model_step();
      chk($sformatf("rnd%0d_valid", c),  80'(move_valid), 80'(m_valid));
      chk($sformatf("rnd%0d_move", c),   80'(move),       80'(m_move));
      chk($sformatf("rnd%0d_landed", c), 80'(landed),     80'(m_landed));
      chk($sformatf("rnd%0d_rej", c),    80'(reject_cnt), 80'(m_rej));
      chk($sformatf("rnd%0d_frame", c),  80'(frame_cur),  80'(m_frame));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_sched.md
MOVE_SCHED -- requirements
Module: move_sched

Interface
REQ-001 SHALL have parameter REPEAT_DLY, default 8, auto-repeat period in cycles for a held button (legal range 2..255).
REQ-002 SHALL have clk  in  1  system clock; one clock domain, all state on rising edge.
REQ-003 SHALL have rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have play  in  1  active-piece phase; 1 = scheduling enabled.
REQ-005 SHALL have btn_right, btn_left, btn_ror, btn_rol  in  1 each  synchronized button levels.
REQ-006 SHALL have drop_tick  in  1  one-cycle gravity pulse.
REQ-007 SHALL have load_frame  in  1  load frame_init into frame_cur, honoured in IDLE only.
REQ-008 SHALL have frame_init  in  [4:0][4:0][2:0]  new-piece frame.
REQ-009 SHALL have trk_frame  in  [4:0][4:0][2:0]  tracker result frame.
REQ-010 SHALL have trk_check  in  1  tracker legality flag; 1 = move legal.
REQ-011 SHALL have trk_complete  in  1  tracker landing flag.
REQ-012 SHALL have move  out  3  move code to tracker: RIGHT=0, LEFT=1, ROR=2, ROL=3, DOWN=4.
REQ-013 SHALL have move_valid  out  1  high while a move is presented to the tracker.
REQ-014 SHALL have frame_cur  out  [4:0][4:0][2:0]  registered current frame; drives tracker frame_i.
REQ-015 SHALL have landed  out  1  one-cycle pulse on piece landing.
REQ-016 SHALL have reject_cnt  out  8  count of illegal moves, saturating at 255.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, LOCKED; reset state IDLE.
REQ-018 SHALL hold one pending bit per move (5 bits); a button rising edge or drop_tick sets the corresponding bit.
REQ-019 SHALL set a button's pending bit again every REPEAT_DLY cycles while the button stays high after its edge; release SHALL clear that button's repeat counter.
REQ-020 SHALL coalesce requests: setting an already-set pending bit has no further effect.
REQ-021 SHALL let set win when set and grant-clear of the same bit occur in one cycle.
REQ-022 IDLE, play=1, any pending bit: SHALL grant by fixed priority DOWN > ROR > ROL > LEFT > RIGHT, clear the granted bit, latch move, and go to ISSUE.
REQ-023 ISSUE SHALL last exactly one cycle with move_valid=1 and move stable.
REQ-024 On leaving ISSUE with trk_check=1: SHALL load frame_cur <= trk_frame; with trk_check=0: SHALL keep frame_cur and increment reject_cnt (saturating).
REQ-025 On leaving ISSUE with move=DOWN and trk_complete=1: SHALL pulse landed for one cycle, clear all pending bits, and go to LOCKED; otherwise SHALL go to IDLE.
REQ-026 Latency: a request registered at edge k SHALL be granted at edge k+1, with frame_cur updated at edge k+2; throughput SHALL be one move per 2 cycles.
REQ-027 LOCKED SHALL ignore and discard all requests; load_frame SHALL load frame_cur and return to IDLE.
REQ-028 IDLE with load_frame=1 SHALL load frame_init, which takes precedence over a grant in the same cycle.
REQ-029 When play=0: SHALL clear pending bits and repeat counters, abort ISSUE without committing, and go to IDLE; load_frame SHALL remain honoured.
REQ-030 move SHALL hold its last value when move_valid=0.

Reset
REQ-031 While rst=0 at a clock edge: state=IDLE, pending=0, repeat counters=0, move=0 (RIGHT), move_valid=0, frame_cur=0, landed=0, reject_cnt=0.
REQ-032 Reset asserted mid-ISSUE SHALL discard the move with no commit and no count.

Verification
REQ-033 Reset, load_frame with a 2x2 block at rows 1-2, cols 1-2, play=1, btn_right edge, trk_check=1, trk_frame shifted -> move=0 and move_valid for 1 cycle; frame_cur=shifted frame 2 cycles after the edge.
REQ-034 drop_tick and btn_ror edge in the same cycle -> DOWN issued first, ROR issued 2 cycles later.
REQ-035 btn_left held 30 cycles, REPEAT_DLY=8, trk_check=1 -> exactly 4 LEFT grants (edge plus 3 repeats).
REQ-036 btn_rol with trk_check=0 repeated 300 times -> frame_cur unchanged; reject_cnt=255.
REQ-037 DOWN with trk_complete=1 -> landed pulse of 1 cycle; a btn_right edge during LOCKED gives no grant; after load_frame the FSM is in IDLE and frame_cur=frame_init.
REQ-038 rst=0 during ISSUE -> frame_cur=0, reject_cnt=0, move_valid=0 on the next cycle.
